ysyx_040750_csr_ctrl: RTL and testbench
=======================================

# ysyx_040750_csr_ctrl

CSR access sequencer for the ysyx_040750 core. It sits between the EX stage and the CSR register file and owns the single CSR read port and single CSR write port. It sequences three request types over multiple cycles: Zicsr read-modify-write through the CSR ALU, ecall trap entry, and mret trap return. It returns the old CSR value and any PC redirect to the pipeline over a valid/ready handshake.

## Interface
Parameters:
- MSTATUS, 12'h300, mstatus address
- MTVEC, 12'h305, mtvec address
- MEPC, 12'h341, mepc address
- MCAUSE, 12'h342, mcause address

Ports:
- I_clk  in  1  single clock; all state updates on rising edge
- I_rst_n  in  1  asynchronous, active-low reset
- I_req_valid  in  1  request offered by EX
- O_req_ready  out  1  high only in IDLE
- I_req_type  in  2  00 CSR op, 01 ecall, 10 mret, 11 illegal
- I_csr_addr  in  12  target CSR for CSR op
- I_csr_op_sel  in  6  one-hot {rw, rs, rc, rwi, rsi, rci}
- I_rs_data  in  64  rs1 value
- I_uimm  in  5  zimm field
- I_src_zero  in  1  rs1 index / uimm is zero
- I_pc  in  64  PC of requesting instruction
- O_csr_raddr  out  12  CSR read address
- I_csr_rdata  in  64  combinational read data
- O_csr_wen  out  1  CSR write enable
- O_csr_waddr  out  12  CSR write address
- O_csr_wdata  out  64  CSR write data
- O_alu_csr_data / O_alu_rs_data / O_alu_uimm / O_alu_op_sel  out  64/64/5/6  CSR ALU operands
- I_alu_result  in  64  CSR ALU result
- O_resp_valid  out  1  response valid
- I_resp_ready  in  1  pipeline accepts response
- O_rd_data  out  64  old CSR value (for rd)
- O_redirect  out  1  response carries PC redirect
- O_redirect_pc  out  64  redirect target

## Operation
- FSM states: IDLE, RMW, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC, RESP.
- IDLE: handshake on I_req_valid & O_req_ready; latch addr, op_sel, rs_data, uimm, src_zero, pc. Next state by type: 00→RMW, 01→T_EPC, 10→R_STAT, 11→RESP with no CSR effect, rd_data=0, redirect=0.
- RMW: raddr=latched addr; ALU operands = I_csr_rdata, latched rs/uimm/op_sel; O_rd_data<=I_csr_rdata. Write wdata=I_alu_result to the same address unless op_sel==0 or (set/clear op and src_zero). Then →RESP.
- T_EPC: write MEPC = {pc[63:2],2'b00} →T_CAUSE.
- T_CAUSE: write MCAUSE = 64'd11 →T_STAT.
- T_STAT: read MSTATUS; write same with bit7(MPIE)=bit3(MIE), bit3=0, bits12:11(MPP)=2'b11 →T_VEC.
- T_VEC: read MTVEC; redirect_pc<={rdata[63:2],2'b00}, redirect<=1 →RESP.
- R_STAT: read MSTATUS; write with bit3=bit7, bit7=1, MPP=2'b11 →R_EPC.
- R_EPC: read MEPC; redirect_pc<=rdata, redirect<=1 →RESP.
- RESP: O_resp_valid=1, outputs held stable until I_resp_ready; then →IDLE, redirect cleared.
- Outside write cycles: wen=0, waddr=0, wdata=0; raddr=0 in IDLE/RESP.

## Timing
- Reset (async, any state): state→IDLE; O_resp_valid, O_redirect, O_redirect_pc, O_rd_data, O_csr_wen, O_csr_waddr, O_csr_wdata, O_csr_raddr all 0; O_req_ready=1 once in IDLE. Partially completed trap writes are not rolled back.
- Latency, accept edge = cycle 0: CSR op resp_valid at cycle 2; illegal at cycle 1; mret at cycle 3; ecall at cycle 5. Each extra cycle of resp_ready low adds one cycle.
- One write per cycle maximum; read data used same cycle (combinational port).
- Requests during non-IDLE ignored (ready=0); no request accepted in the RESP→IDLE transition cycle.

## Test plan
- Reset mid-ecall (in T_STAT): drop I_rst_n → all outputs 0 same cycle; after release, ready=1, mepc/mcause writes already done remain.
- csrrw 0x340, rs=0xDEAD_BEEF, old 0x1234 → cycle 1 write 0x340←0xDEADBEEF; cycle 2 resp_valid, rd_data=0x1234, redirect=0.
- csrrs 0x300, src_zero=1 → no wen pulse; rd_data = current mstatus.
- csrrci 0x300 uimm=8, mstatus=0x8 → write 0x0; hold resp_ready low 3 cycles → resp stable, ready=0, new valid ignored.
- ecall pc=0x8000_0010, mtvec=0x8000_0101, mstatus=0x8 → writes mepc=0x80000010, mcause=11, mstatus=0x1880; resp at cycle 5 with redirect_pc=0x80000100.
- mret with mstatus=0x1880, mepc=0x8000_0014 → mstatus←0x1888; resp at cycle 3, redirect_pc=0x80000014.

Source files
------------

// File: rtl/ysyx_040750_csr_ctrl.sv
// CSR access sequencer: owns the single CSR read/write port pair and steps
// Zicsr read-modify-write, ecall trap entry and mret trap return over several cycles.
module ysyx_040750_csr_ctrl #(
    parameter logic [11:0] MSTATUS = 12'h300,
    parameter logic [11:0] MTVEC   = 12'h305,
    parameter logic [11:0] MEPC    = 12'h341,
    parameter logic [11:0] MCAUSE  = 12'h342
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic [1:0]  I_req_type,
    input  logic [11:0] I_csr_addr,
    input  logic [5:0]  I_csr_op_sel,
    input  logic [63:0] I_rs_data,
    input  logic [4:0]  I_uimm,
    input  logic        I_src_zero,
    input  logic [63:0] I_pc,
    output logic [11:0] O_csr_raddr,
    input  logic [63:0] I_csr_rdata,
    output logic        O_csr_wen,
    output logic [11:0] O_csr_waddr,
    output logic [63:0] O_csr_wdata,
    output logic [63:0] O_alu_csr_data,
    output logic [63:0] O_alu_rs_data,
    output logic [4:0]  O_alu_uimm,
    output logic [5:0]  O_alu_op_sel,
    input  logic [63:0] I_alu_result,
    output logic        O_resp_valid,
    input  logic        I_resp_ready,
    output logic [63:0] O_rd_data,
    output logic        O_redirect,
    output logic [63:0] O_redirect_pc
);

    typedef enum logic [3:0] {
        S_IDLE, S_RMW, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC, S_RESP
    } state_t;

    state_t      state;
    logic [11:0] addr_q;
    logic [5:0]  op_q;
    logic [63:0] rs_q;
    logic [4:0]  uimm_q;
    logic        zero_q;
    logic [61:0] pc_q;
    logic [63:0] rd_q;
    logic [63:0] rpc_q;
    logic        redir_q;

    // Set/clear variants (rs, rc, rsi, rci) with a zero source must not write.
    logic set_clr;
    logic rmw_wr;
    assign set_clr = |(op_q & 6'b011011);
    assign rmw_wr  = (op_q != 6'd0) && !(set_clr && zero_q);

    assign O_req_ready   = (state == S_IDLE);
    assign O_resp_valid  = (state == S_RESP);
    assign O_rd_data     = rd_q;
    assign O_redirect    = redir_q;
    assign O_redirect_pc = rpc_q;

    always_comb begin
        O_csr_raddr    = '0;
        O_csr_wen      = 1'b0;
        O_csr_waddr    = '0;
        O_csr_wdata    = '0;
        O_alu_csr_data = '0;
        O_alu_rs_data  = '0;
        O_alu_uimm     = '0;
        O_alu_op_sel   = '0;
        case (state)
            S_RMW: begin
                O_csr_raddr    = addr_q;
                O_alu_csr_data = I_csr_rdata;
                O_alu_rs_data  = rs_q;
                O_alu_uimm     = uimm_q;
                O_alu_op_sel   = op_q;
                if (rmw_wr) begin
                    O_csr_wen   = 1'b1;
                    O_csr_waddr = addr_q;
                    O_csr_wdata = I_alu_result;
                end
            end
            S_T_EPC: begin
                O_csr_wen   = 1'b1;
                O_csr_waddr = MEPC;
                O_csr_wdata = {pc_q, 2'b00};
            end
            S_T_CAUSE: begin
                O_csr_wen   = 1'b1;
                O_csr_waddr = MCAUSE;
                O_csr_wdata = 64'd11;
            end
            S_T_STAT: begin
                // MPIE <= MIE, MIE <= 0, MPP <= M
                O_csr_raddr        = MSTATUS;
                O_csr_wen          = 1'b1;
                O_csr_waddr        = MSTATUS;
                O_csr_wdata        = I_csr_rdata;
                O_csr_wdata[7]     = I_csr_rdata[3];
                O_csr_wdata[3]     = 1'b0;
                O_csr_wdata[12:11] = 2'b11;
            end
            S_T_VEC: O_csr_raddr = MTVEC;
            S_R_STAT: begin
                // MIE <= MPIE, MPIE <= 1, MPP stays M (M-only core)
                O_csr_raddr        = MSTATUS;
                O_csr_wen          = 1'b1;
                O_csr_waddr        = MSTATUS;
                O_csr_wdata        = I_csr_rdata;
                O_csr_wdata[3]     = I_csr_rdata[7];
                O_csr_wdata[7]     = 1'b1;
                O_csr_wdata[12:11] = 2'b11;
            end
            S_R_EPC: O_csr_raddr = MEPC;
            default: ;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            uimm_q  <= '0;
            zero_q  <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            rpc_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (I_req_valid) begin
                    addr_q  <= I_csr_addr;
                    op_q    <= I_csr_op_sel;
                    rs_q    <= I_rs_data;
                    uimm_q  <= I_uimm;
                    zero_q  <= I_src_zero;
                    pc_q    <= I_pc[63:2];
                    rd_q    <= '0;
                    rpc_q   <= '0;
                    redir_q <= 1'b0;
                    case (I_req_type)
                        2'b00:   state <= S_RMW;
                        2'b01:   state <= S_T_EPC;
                        2'b10:   state <= S_R_STAT;
                        default: state <= S_RESP;
                    endcase
                end
                S_RMW: begin
                    rd_q  <= I_csr_rdata;
                    state <= S_RESP;
                end
                S_T_EPC:   state <= S_T_CAUSE;
                S_T_CAUSE: state <= S_T_STAT;
                S_T_STAT:  state <= S_T_VEC;
                S_T_VEC: begin
                    rpc_q   <= {I_csr_rdata[63:2], 2'b00};
                    redir_q <= 1'b1;
                    state   <= S_RESP;
                end
                S_R_STAT:  state <= S_R_EPC;
                S_R_EPC: begin
                    rpc_q   <= I_csr_rdata;
                    redir_q <= 1'b1;
                    state   <= S_RESP;
                end
                S_RESP: if (I_resp_ready) begin
                    redir_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040750_csr_ctrl.sv
// Self-checking bench for ysyx_040750_csr_ctrl: directed scenarios plus random
// requests against a transaction-level CSR model.
module tb_ysyx_040750_csr_ctrl;
    localparam logic [11:0] MSTATUS = 12'h300, MTVEC = 12'h305, MEPC = 12'h341,
                            MCAUSE = 12'h342, MSCRATCH = 12'h340;

    logic        I_clk = 1'b0, I_rst_n = 1'b0;
    logic        I_req_valid = 1'b0, I_resp_ready = 1'b0, I_src_zero = 1'b0;
    logic [1:0]  I_req_type = '0;
    logic [11:0] I_csr_addr = '0;
    logic [5:0]  I_csr_op_sel = '0;
    logic [63:0] I_rs_data = '0, I_pc = '0;
    logic [4:0]  I_uimm = '0;
    logic        O_req_ready, O_csr_wen, O_resp_valid, O_redirect;
    logic [11:0] O_csr_raddr, O_csr_waddr;
    logic [63:0] O_csr_wdata, O_alu_csr_data, O_alu_rs_data, O_rd_data, O_redirect_pc;
    logic [4:0]  O_alu_uimm;
    logic [5:0]  O_alu_op_sel;
    logic [63:0] I_csr_rdata, I_alu_result;

    int checks = 0, errors = 0;

    ysyx_040750_csr_ctrl dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
        .I_req_type(I_req_type), .I_csr_addr(I_csr_addr), .I_csr_op_sel(I_csr_op_sel),
        .I_rs_data(I_rs_data), .I_uimm(I_uimm), .I_src_zero(I_src_zero), .I_pc(I_pc),
        .O_csr_raddr(O_csr_raddr), .I_csr_rdata(I_csr_rdata), .O_csr_wen(O_csr_wen),
        .O_csr_waddr(O_csr_waddr), .O_csr_wdata(O_csr_wdata), .O_alu_csr_data(O_alu_csr_data),
        .O_alu_rs_data(O_alu_rs_data), .O_alu_uimm(O_alu_uimm), .O_alu_op_sel(O_alu_op_sel),
        .I_alu_result(I_alu_result), .O_resp_valid(O_resp_valid), .I_resp_ready(I_resp_ready),
        .O_rd_data(O_rd_data), .O_redirect(O_redirect), .O_redirect_pc(O_redirect_pc)
    );

    always #5 I_clk = ~I_clk;

    // Zicsr ALU semantics; also serves as the external CSR ALU the block drives.
    function automatic logic [63:0] csr_alu(input logic [5:0] op, input logic [63:0] c,
                                            input logic [63:0] rs, input logic [4:0] u);
        logic [63:0] z;
        z = {59'd0, u};
        case (op)
            6'b100000: return rs;
            6'b010000: return c | rs;
            6'b001000: return c & ~rs;
            6'b000100: return z;
            6'b000010: return c | z;
            6'b000001: return c & ~z;
            default:   return c;
        endcase
    endfunction

    // CSR register file environment (written by DUT or by a backdoor poke)
    logic [63:0] csr_mem [0:4095];
    logic [63:0] model   [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [63:0] poke_data = '0;
    int          wr_cnt = 0;

    assign I_csr_rdata  = csr_mem[O_csr_raddr];
    assign I_alu_result = csr_alu(O_alu_op_sel, O_alu_csr_data, O_alu_rs_data, O_alu_uimm);

    always @(posedge I_clk) begin
        if (poke_en) csr_mem[poke_addr] <= poke_data;
        else if (O_csr_wen) begin
            csr_mem[O_csr_waddr] <= O_csr_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [63:0] d);
        @(negedge I_clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        model[a] = d;
        @(posedge I_clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic cmp_mem();
        logic [11:0] al [5];
        al = '{MSTATUS, MTVEC, MEPC, MCAUSE, MSCRATCH};
        foreach (al[i]) chk($sformatf("csr_%h", al[i]), csr_mem[al[i]], model[al[i]]);
    endtask

    task automatic txn(input logic [1:0] typ, input logic [11:0] addr, input logic [5:0] op,
                       input logic [63:0] rs, input logic [4:0] u, input logic zero,
                       input logic [63:0] pc, input int hold);
        logic [63:0] exp_rd, exp_rpc, s;
        logic        exp_redir;
        int          exp_lat, exp_wr, lat, w0;
        exp_rd = 0; exp_rpc = 0; exp_redir = 0; exp_wr = 0; exp_lat = 1;
        case (typ)
            2'b00: begin
                exp_lat = 2;
                exp_rd  = model[addr];
                if (op != 0 && !((op == 6'b010000 || op == 6'b001000 || op == 6'b000010 ||
                                  op == 6'b000001) && zero)) begin
                    model[addr] = csr_alu(op, model[addr], rs, u);
                    exp_wr = 1;
                end
            end
            2'b01: begin
                exp_lat = 5; exp_wr = 3; exp_redir = 1;
                model[MEPC] = pc & ~64'd3;
                model[MCAUSE] = 64'd11;
                s = model[MSTATUS];
                s[7] = s[3]; s[3] = 1'b0; s[12:11] = 2'b11;
                model[MSTATUS] = s;
                exp_rpc = model[MTVEC] & ~64'd3;
            end
            2'b10: begin
                exp_lat = 3; exp_wr = 1; exp_redir = 1;
                s = model[MSTATUS];
                s[3] = s[7]; s[7] = 1'b1; s[12:11] = 2'b11;
                model[MSTATUS] = s;
                exp_rpc = model[MEPC];
            end
            default: ;
        endcase
        @(negedge I_clk);
        chk("req_ready_idle", O_req_ready, 1);
        I_req_type = typ; I_csr_addr = addr; I_csr_op_sel = op; I_rs_data = rs;
        I_uimm = u; I_src_zero = zero; I_pc = pc; I_req_valid = 1'b1;
        w0 = wr_cnt;
        @(posedge I_clk); #1;
        // junk request kept on the bus while busy; must be ignored
        I_req_valid = 1'b1; I_req_type = 2'($urandom); I_csr_addr = MSCRATCH;
        I_csr_op_sel = 6'b100000; I_rs_data = {$urandom, $urandom}; I_pc = {$urandom, $urandom};
        @(negedge I_clk);
        lat = 1;
        while (!O_resp_valid && lat < 12) begin
            chk("req_ready_busy", O_req_ready, 0);
            @(negedge I_clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", O_resp_valid, 1);
            chk("req_ready_resp", O_req_ready, 0);
            chk("rd_data", O_rd_data, exp_rd);
            chk("redirect", O_redirect, exp_redir);
            chk("redirect_pc", O_redirect_pc, exp_rpc);
            if (h < hold) @(negedge I_clk);
        end
        I_resp_ready = 1'b1;
        @(posedge I_clk); #1;
        I_resp_ready = 1'b0; I_req_valid = 1'b0;
        chk("resp_valid_drop", O_resp_valid, 0);
        chk("redirect_clear", O_redirect, 0);
        chk("wr_count", 64'(wr_cnt - w0), 64'(exp_wr));
        cmp_mem();
    endtask

    initial begin
        logic [5:0] op;
        logic [11:0] al [5];
        al = '{MSTATUS, MTVEC, MEPC, MCAUSE, MSCRATCH};
        repeat (2) @(negedge I_clk);
        chk("rst_resp_valid", O_resp_valid, 0);
        chk("rst_wen", O_csr_wen, 0);
        chk("rst_raddr", O_csr_raddr, 0);
        chk("rst_redirect", O_redirect, 0);
        chk("rst_rd_data", O_rd_data, 0);
        I_rst_n = 1'b1;
        @(negedge I_clk);
        chk("rst_ready", O_req_ready, 1);
        foreach (al[i]) poke(al[i], 64'd0);

        poke(MSCRATCH, 64'h1234);
        txn(2'b00, MSCRATCH, 6'b100000, 64'hDEAD_BEEF, 5'd0, 1'b0, 64'h0, 0);
        chk("csrrw_val", csr_mem[MSCRATCH], 64'hDEAD_BEEF);
        poke(MSTATUS, 64'h8);
        txn(2'b00, MSTATUS, 6'b010000, 64'hFF, 5'd0, 1'b1, 64'h0, 0);
        txn(2'b00, MSTATUS, 6'b000001, 64'h0, 5'd8, 1'b0, 64'h0, 3);
        chk("csrrci_val", csr_mem[MSTATUS], 64'h0);
        txn(2'b11, MSCRATCH, 6'b100000, 64'h55, 5'd0, 1'b0, 64'h0, 1);
        poke(MTVEC, 64'h8000_0101);
        poke(MSTATUS, 64'h8);
        txn(2'b01, 12'h0, 6'b0, 64'h0, 5'd0, 1'b0, 64'h8000_0010, 0);
        chk("ecall_mstatus", csr_mem[MSTATUS], 64'h1880);
        poke(MEPC, 64'h8000_0014);
        txn(2'b10, 12'h0, 6'b0, 64'h0, 5'd0, 1'b0, 64'h0, 0);
        chk("mret_mstatus", csr_mem[MSTATUS], 64'h1888);

        // reset while the ecall sits in its mstatus-update cycle
        poke(MSTATUS, 64'h8);
        @(negedge I_clk);
        I_req_type = 2'b01; I_pc = 64'h8000_0040; I_req_valid = 1'b1;
        @(posedge I_clk); #1;
        I_req_valid = 1'b0;
        repeat (2) @(posedge I_clk);
        @(negedge I_clk);
        chk("pre_rst_raddr", O_csr_raddr, MSTATUS);
        I_rst_n = 1'b0;
        #1;
        chk("arst_wen", O_csr_wen, 0);
        chk("arst_waddr", O_csr_waddr, 0);
        chk("arst_wdata", O_csr_wdata, 0);
        chk("arst_raddr", O_csr_raddr, 0);
        chk("arst_resp_valid", O_resp_valid, 0);
        chk("arst_redirect", O_redirect, 0);
        chk("arst_redirect_pc", O_redirect_pc, 0);
        chk("arst_rd_data", O_rd_data, 0);
        model[MEPC] = 64'h8000_0040;
        model[MCAUSE] = 64'd11;
        @(negedge I_clk);
        I_rst_n = 1'b1;
        @(negedge I_clk);
        chk("arst_ready", O_req_ready, 1);
        cmp_mem();

        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 6) == 0) ? 6'd0 : 6'(1 << $urandom_range(0, 5));
            txn(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                al[$urandom_range(0, 4)], op, {$urandom, $urandom}, 5'($urandom),
                ($urandom_range(0, 3) == 0), {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
